// File: rtl/dmem_lsu_ram.sv
// Byte-addressable data memory with a valid/ready load/store port, synchronous read and registered response pipeline.
module dmem_lsu_ram #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "RAM.txt"
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_write,
    input  logic [1:0]                             req_size,
    input  logic                                   req_unsigned,
    input  logic [$clog2(DEPTH*DATA_WIDTH/8)-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]                  req_wdata,
    output logic                                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                  rsp_rdata,
    output logic                                   rsp_fault
);

    localparam int unsigned AW = $clog2(DEPTH * DATA_WIDTH / 8);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned IW = AW - LB;

    typedef struct packed {
        logic          valid;
        logic          fault;
        logic          load;
        logic          uns;
        logic [1:0]    size;
        logic [LB-1:0] lane;
    } meta_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready_q, ready_d;
    meta_t                 meta_q [READ_LATENCY];
    meta_t                 meta_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_q [READ_LATENCY];

    logic                  accept;
    logic                  fault;
    logic [LB-1:0]         lane;
    logic [LB-1:0]         align_mask;
    logic [IW-1:0]         widx;
    logic [NB-1:0]         byte_we;
    logic [DATA_WIDTH-1:0] wdata_sh;

    meta_t                 last;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;

    // Ready drops combinationally with RESET so nothing is accepted on a reset edge.
    assign req_ready = ready_q && !RESET;

    // Request decode: address split, alignment check, byte-lane write enables.
    always_comb begin
        accept     = req_valid && req_ready;
        lane       = req_addr[LB-1:0];
        widx       = req_addr[AW-1:LB];
        align_mask = LB'((4'd1 << req_size) - 4'd1);
        fault      = ((lane & align_mask) != '0) || ((req_size == 2'b11) && (NB == 4));
        wdata_sh   = req_wdata << {lane, 3'b000};
        byte_we    = '0;
        for (int k = 0; k < int'(NB); k++) begin
            byte_we[k] = accept && req_write && !fault
                         && (k >= int'(lane))
                         && (k < int'(lane) + (1 << req_size));
        end
    end

    // Next state for the ready flag and the response metadata pipeline.
    always_comb begin
        ready_d         = 1'b1;
        meta_d[0].valid = accept;
        meta_d[0].fault = accept && fault;
        meta_d[0].load  = !req_write;
        meta_d[0].uns   = req_unsigned;
        meta_d[0].size  = req_size;
        meta_d[0].lane  = lane;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            meta_d[i] = meta_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ready_q <= 1'b0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            ready_q <= ready_d;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                meta_q[i] <= meta_d[i];
            end
        end
    end

    // Array and read-data pipeline; no reset so the array maps onto block RAM.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < int'(NB); k++) begin
            if (byte_we[k]) begin
                mem[widx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
        if (accept) begin
            data_q[0] <= mem[widx];
        end
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign last    = meta_q[READ_LATENCY-1];
    assign shifted = data_q[READ_LATENCY-1] >> {last.lane, 3'b000};

    // Lane-aligned data extended to the full word according to size and signedness.
    always_comb begin
        ext = shifted;
        case (last.size)
            2'd0: ext = last.uns ? DATA_WIDTH'(shifted[7:0])
                                 : DATA_WIDTH'($signed(shifted[7:0]));
            2'd1: ext = last.uns ? DATA_WIDTH'(shifted[15:0])
                                 : DATA_WIDTH'($signed(shifted[15:0]));
            2'd2: ext = last.uns ? DATA_WIDTH'(shifted[31:0])
                                 : DATA_WIDTH'($signed(shifted[31:0]));
            default: ext = shifted;
        endcase
    end

    assign rsp_valid = last.valid;
    assign rsp_fault = last.fault;
    assign rsp_rdata = (last.valid && last.load && !last.fault) ? ext : '0;

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Bench for dmem_lsu_ram: a 32-bit/latency-1 and a 64-bit/latency-3 instance share one request stream,
// each checked against a byte-array reference model and a due-cycle response queue.
module tb_dmem_lsu_ram;

    localparam int unsigned AW = 12;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;

    logic          rdy0, rdy1, v0, v1, f0, f1;
    logic [31:0]   rd0;
    logic [63:0]   rd1;

    dmem_lsu_ram #(.DEPTH(1024), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_FILE("RAM.txt")) u_l1 (
        .CLK(clk), .RESET(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(v0), .rsp_rdata(rd0), .rsp_fault(f0)
    );

    dmem_lsu_ram #(.DEPTH(512), .DATA_WIDTH(64), .READ_LATENCY(3), .INIT_FILE("RAM.txt")) u_l3 (
        .CLK(clk), .RESET(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v1), .rsp_rdata(rd1), .rsp_fault(f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          fault;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [11:0] addr;
        logic [31:0] wd;
        bit          efault;
        logic [31:0] erd;
    } vec_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  mem_m [2][4096];
    int          edge_n;
    bit          rdy_m;
    int          n_checks;
    int          n_fail;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Reference behaviour of one accepted request for instance d (0: 32-bit/L1, 1: 64-bit/L3).
    function automatic exp_t model_req(int d);
        exp_t        e;
        int          sb;
        int          dw;
        int          a;
        logic [63:0] v;
        sb      = 1 << req_size;
        dw      = (d == 0) ? 32 : 64;
        a       = int'(req_addr);
        e.due   = edge_n + ((d == 0) ? 1 : 3) - 1;
        e.fault = ((req_size == 2'd3) && (dw == 32)) || ((a % sb) != 0);
        e.rdata = '0;
        v       = '0;
        if (!e.fault) begin
            if (req_write) begin
                for (int i = 0; i < sb; i++) mem_m[d][a+i] = req_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < sb; i++) v[8*i +: 8] = mem_m[d][a+i];
                if (!req_unsigned && (sb * 8 < dw) && v[sb*8-1]) begin
                    for (int b = sb * 8; b < dw; b++) v[b] = 1'b1;
                end
                e.rdata = v;
            end
        end
        return e;
    endfunction

    function automatic void check_dut(int d, logic v, logic f, logic [63:0] r);
        exp_t e;
        bit   ev;
        ev = 1'b0;
        e  = '{0, 1'b0, 64'h0};
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].due == edge_n) begin
                ev = 1'b1;
                e  = q0.pop_front();
            end
        end else begin
            if (q1.size() > 0 && q1[0].due == edge_n) begin
                ev = 1'b1;
                e  = q1.pop_front();
            end
        end
        chk($sformatf("rsp_valid[%0d]", d), 64'(v), 64'(ev));
        if (ev) begin
            chk($sformatf("rsp_fault[%0d]", d), 64'(f), 64'(e.fault));
            chk($sformatf("rsp_rdata[%0d]", d), r, e.rdata);
        end
    endfunction

    // One clock: check ready before the edge, update the model at the edge, check responses after it.
    task automatic tick();
        #1;
        chk("req_ready[0]", 64'(rdy0), 64'(!rst && rdy_m));
        chk("req_ready[1]", 64'(rdy1), 64'(!rst && rdy_m));
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q0.delete();
            q1.delete();
            rdy_m = 1'b0;
        end else begin
            if (req_valid && rdy_m) begin
                q0.push_back(model_req(0));
                q1.push_back(model_req(1));
            end
            rdy_m = 1'b1;
        end
        #1;
        check_dut(0, v0, f0, 64'(rd0));
        check_dut(1, v1, f1, rd1);
    endtask

    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [11:0] addr, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    vec_t vt[18];
    bit [7:0] pulses;
    int       got;
    int       a;
    logic [1:0] sz;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;
        rdy_m    = 1'b0;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 12'h013, 32'h80,       1'b0, 32'h00000000};
        vt[3]  = '{1'b0, 2'd0, 1'b0, 12'h013, 32'h0,        1'b0, 32'hFFFFFF80};
        vt[4]  = '{1'b0, 2'd0, 1'b1, 12'h013, 32'h0,        1'b0, 32'h00000080};
        vt[5]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 32'h80ADBEEF};
        vt[6]  = '{1'b1, 2'd1, 1'b0, 12'h011, 32'hAAAA,     1'b1, 32'h00000000};
        vt[7]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 32'h80ADBEEF};
        vt[8]  = '{1'b0, 2'd3, 1'b0, 12'h010, 32'h0,        1'b1, 32'h00000000};
        vt[9]  = '{1'b1, 2'd1, 1'b0, 12'h012, 32'h1234,     1'b0, 32'h00000000};
        vt[10] = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 32'h1234BEEF};
        vt[11] = '{1'b0, 2'd1, 1'b0, 12'h012, 32'h0,        1'b0, 32'h00001234};
        vt[12] = '{1'b1, 2'd1, 1'b0, 12'h014, 32'h8001,     1'b0, 32'h00000000};
        vt[13] = '{1'b0, 2'd1, 1'b0, 12'h014, 32'h0,        1'b0, 32'hFFFF8001};
        vt[14] = '{1'b0, 2'd1, 1'b1, 12'h014, 32'h0,        1'b0, 32'h00008001};
        vt[15] = '{1'b1, 2'd2, 1'b0, 12'h016, 32'h0,        1'b1, 32'h00000000};
        vt[16] = '{1'b0, 2'd0, 1'b0, 12'h011, 32'h0,        1'b0, 32'hFFFFFFBE};
        vt[17] = '{1'b0, 2'd1, 1'b1, 12'h010, 32'h0,        1'b0, 32'h0000BEEF};

        // Reset held with a store pending: it must never be accepted.
        rst = 1'b1;
        issue(1'b1, 2'd2, 1'b0, 12'h010, 64'h1111);
        tick();
        tick();
        chk("rst_rdata[0]", 64'(rd0), 64'h0);
        chk("rst_fault[0]", 64'(f0), 64'h0);
        chk("rst_rdata[1]", rd1, 64'h0);
        chk("rst_fault[1]", 64'(f1), 64'h0);
        rst = 1'b0;
        tick();

        // Zero the low 256 bytes so every later load reads defined data.
        for (int i = 0; i < 256; i += 4) begin
            issue(1'b1, 2'd2, 1'b0, 12'(i), 64'h0);
            tick();
        end

        for (int i = 0; i < 18; i++) begin
            issue(vt[i].wr, vt[i].sz, vt[i].uns, vt[i].addr, {32'h0, vt[i].wd});
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(v0), 64'h1);
            chk($sformatf("vec%0d_fault", i), 64'(f0), 64'(vt[i].efault));
            chk($sformatf("vec%0d_rdata", i), 64'(rd0), 64'(vt[i].erd));
        end

        // Four back-to-back loads on the latency-3 instance.
        idle();
        repeat (4) tick();
        pulses = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) issue(1'b0, 2'd2, 1'b0, 12'(16 + 4 * k), 64'h0);
            else idle();
            tick();
            pulses[k] = v1;
        end
        chk("l3_pulse_pattern", 64'(pulses), 64'h3C);

        // Reset with two loads in flight on the latency-3 instance.
        idle();
        repeat (4) tick();
        pulses = '0;
        for (int k = 0; k < 7; k++) begin
            rst = (k == 2);
            if (k < 2) issue(1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
            else idle();
            tick();
            pulses[k] = v1;
        end
        chk("rst_flush_pulses", 64'(pulses), 64'h0);

        // Normal service resumes after the flush.
        issue(1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
        tick();
        idle();
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            tick();
            if (v1 === 1'b1) got = 1;
        end
        chk("resume_rsp", 64'(got), 64'h1);

        // Random traffic with occasional resets; the array keeps its contents across them.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            sz  = 2'($urandom_range(0, 3));
            a   = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            if ($urandom_range(0, 3) != 0)
                issue(($urandom_range(0, 9) < 4), sz, 1'($urandom_range(0, 1)), 12'(a),
                      {32'($urandom), 32'($urandom)});
            else
                idle();
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
